fft_input_loader: RTL and testbench
===================================

FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 SHALL have parameter POINTS, default 1024, number of complex samples per frame (power of 2, >=4).
REQ-002 SHALL have parameter STAGES, default 10, log2(POINTS).
REQ-003 SHALL have parameter WORDLEN, default 32, memory word width; holds two complex samples of WORDLEN/4 bits per component.
REQ-004 SHALL have port clk_i  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start_i  input  1  arm loader for one frame (sampled in IDLE only).
REQ-007 SHALL have port s_axis_tdata  input  WORDLEN/2  sample: [WORDLEN/2-1:WORDLEN/4]=real, [WORDLEN/4-1:0]=imag, two's complement.
REQ-008 SHALL have ports s_axis_tvalid input 1, s_axis_tready output 1, s_axis_tlast input 1 (AXI-Stream slave).
REQ-009 SHALL have port mem_en_o  output  1  memory port enable.
REQ-010 SHALL have port mem_we_o  output  1  memory write strobe.
REQ-011 SHALL have port mem_addr_o  output  STAGES-1  word address.
REQ-012 SHALL have port mem_wdata_o  output  WORDLEN  packed word, sample 2k in upper half, 2k+1 in lower half.
REQ-013 SHALL have ports busy_o output 1 (frame in progress), done_o output 1 (one-cycle pulse, frame in memory; drives FFT run), tlast_err_o output 1 (sticky framing error).

Function
REQ-014 SHALL implement states IDLE, LOAD_EVEN, LOAD_ODD, FLUSH.
REQ-015 IDLE: tready=0, busy_o=0; start_i=1 -> LOAD_EVEN, sample counter=0, tlast_err_o cleared.
REQ-016 LOAD_EVEN/LOAD_ODD: tready=1; a sample is accepted only when tvalid&&tready in same cycle.
REQ-017 LOAD_EVEN acceptance: capture sample into upper-half holding register, -> LOAD_ODD.
REQ-018 LOAD_ODD acceptance: register write next cycle: mem_en_o=mem_we_o=1, mem_addr_o=counter>>1, wdata={held, current}; -> LOAD_EVEN, or FLUSH if counter==POINTS-1.
REQ-019 Write latency: exactly one cycle from odd-sample handshake to mem_we_o pulse; back-to-back samples sustain one sample/cycle, one write per two cycles.
REQ-020 Counter SHALL increment by one per accepted sample, width STAGES+1 bits, never wrap within a frame.
REQ-021 FLUSH: tready=0; one cycle after final write, done_o=1 for exactly one cycle, -> IDLE.
REQ-022 tlast asserted on sample POINTS-1 is normal; tlast on any other sample, or absent on sample POINTS-1, SHALL set tlast_err_o; loading continues by count regardless.
REQ-023 mem_en_o/mem_we_o SHALL be 0 in every cycle without a write; mem_addr_o/mem_wdata_o hold last value.
REQ-024 start_i outside IDLE SHALL be ignored.

Reset
REQ-025 rst_i=1 at any clock edge, including mid-frame, SHALL force IDLE, counter=0, holding register=0, s_axis_tready=0, mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, done_o=0, tlast_err_o=0; a partial frame is abandoned, no pending write issued.

Structure
REQ-026 State enum and sample-field width constants SHALL live in the shared FFT package.
REQ-027 Single module, no sub-modules; bit packing SHALL be a package function.

Verification
REQ-028 POINTS=1024, samples n with re=n[7:0], im=~n[7:0], tvalid constant, tlast on n=1023 -> 512 writes, addr k gets {2k,~2k,2k+1,~(2k+1)} bytes, done_o one pulse 1 cycle after addr 511 write, tlast_err_o=0.
REQ-029 Random tvalid gaps (50%) on same frame -> identical memory image, no write between even and odd handshake.
REQ-030 tlast on n=500 -> tlast_err_o=1 from next cycle, all 1024 samples still written, done_o pulses.
REQ-031 rst_i asserted after n=301 accepted -> next cycle all outputs at reset values; new start_i reloads from address 0.
REQ-032 start_i pulsed during LOAD_ODD -> no effect; start_i with tvalid=0 for 20 cycles -> tready=1, no writes, busy_o=1.

Source files
------------

// File: rtl/fft_input_loader_pkg.sv
// Shared FFT definitions: loader state encoding, sample-field geometry and
// the helper that packs two streamed samples into one memory word.
package fft_input_loader_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_EVEN = 2'd1,
    LOAD_ODD  = 2'd2,
    FLUSH     = 2'd3
  } load_state_e;

  // A memory word holds two complex samples, each a {real, imag} pair.
  localparam int SAMPLES_PER_WORD = 2;
  localparam int COMPS_PER_SAMPLE = 2;

  // Widest sample the packing helper supports; callers cast down to their word.
  localparam int PACK_MAX_W = 64;

  // Even sample lands in the upper half, odd sample in the lower half.
  function automatic logic [2*PACK_MAX_W-1:0] pack_pair(
    input logic [PACK_MAX_W-1:0] even_s,
    input logic [PACK_MAX_W-1:0] odd_s,
    input int unsigned           sample_w
  );
    logic [2*PACK_MAX_W-1:0] even_w;
    logic [2*PACK_MAX_W-1:0] odd_w;
    even_w = {{PACK_MAX_W{1'b0}}, even_s};
    odd_w  = {{PACK_MAX_W{1'b0}}, odd_s};
    return (even_w << sample_w) | odd_w;
  endfunction

endpackage

// File: rtl/fft_input_loader.sv
// Streams one frame of complex samples from AXI-Stream into FFT working
// memory, two samples per word, then pulses done to launch the transform.
module fft_input_loader
  import fft_input_loader_pkg::*;
#(
  parameter int POINTS  = 1024,
  parameter int STAGES  = 10,
  parameter int WORDLEN = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WORDLEN/2-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [STAGES-2:0]    mem_addr_o,
  output logic [WORDLEN-1:0]   mem_wdata_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tlast_err_o
);

  localparam int              SAMPLE_W = WORDLEN / SAMPLES_PER_WORD;
  localparam logic [STAGES:0] LAST_IDX = (STAGES+1)'(POINTS - 1);

  load_state_e         state_q, state_d;
  logic [STAGES:0]     cnt_q;
  logic [SAMPLE_W-1:0] hold_q;
  logic                accept;
  logic                last_sample;

  assign last_sample = (cnt_q == LAST_IDX);
  assign accept      = s_axis_tvalid && s_axis_tready;
  assign busy_o      = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    case (state_q)
      IDLE:      if (start_i) state_d = LOAD_EVEN;
      LOAD_EVEN: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_d = LOAD_ODD;
      end
      LOAD_ODD:  begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_d = last_sample ? FLUSH : LOAD_EVEN;
      end
      FLUSH:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath: the write for an odd sample is registered, so it appears on
  // the memory port exactly one cycle after its handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      hold_q      <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      done_o      <= 1'b0;
      tlast_err_o <= 1'b0;
    end else begin
      mem_en_o <= 1'b0;
      mem_we_o <= 1'b0;
      done_o   <= (state_q == FLUSH);
      if (state_q == IDLE && start_i) begin
        cnt_q       <= '0;
        tlast_err_o <= 1'b0;
      end
      if (accept) begin
        cnt_q <= cnt_q + (STAGES+1)'(1);
        // Framing is checked but never steers loading; the count rules.
        if (s_axis_tlast != last_sample) tlast_err_o <= 1'b1;
        if (state_q == LOAD_EVEN) begin
          hold_q <= s_axis_tdata;
        end else begin
          mem_en_o    <= 1'b1;
          mem_we_o    <= 1'b1;
          mem_addr_o  <= cnt_q[STAGES-1:1];
          mem_wdata_o <= WORDLEN'(pack_pair(PACK_MAX_W'(hold_q),
                                            PACK_MAX_W'(s_axis_tdata),
                                            SAMPLE_W));
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: full frames (steady, gapped, bad tlast),
// mid-frame reset, stray start pulses and a stalled stream.
module tb_fft_input_loader;

  localparam int POINTS  = 1024;
  localparam int STAGES  = 10;
  localparam int WORDLEN = 32;
  localparam int WORDS   = POINTS / 2;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 start_i = 1'b0;
  logic [WORDLEN/2-1:0] s_axis_tdata = '0;
  logic                 s_axis_tvalid = 1'b0;
  logic                 s_axis_tready;
  logic                 s_axis_tlast = 1'b0;
  logic                 mem_en_o, mem_we_o;
  logic [STAGES-2:0]    mem_addr_o;
  logic [WORDLEN-1:0]   mem_wdata_o;
  logic                 busy_o, done_o, tlast_err_o;

  fft_input_loader #(.POINTS(POINTS), .STAGES(STAGES), .WORDLEN(WORDLEN)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .busy_o(busy_o), .done_o(done_o),
    .tlast_err_o(tlast_err_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] samp(input int n);
    logic [7:0] b;
    b = n[7:0];
    return {b, ~b};
  endfunction

  function automatic logic [31:0] exp_word(input int k);
    logic [7:0] a, b;
    int ia, ib;
    ia = 2 * k;
    ib = 2 * k + 1;
    a = ia[7:0];
    b = ib[7:0];
    return {a, ~a, b, ~b};
  endfunction

  // Memory and timing monitor, sampled on the falling edge.
  logic [31:0] mem_img [WORDS];
  int   cyc = 0, wr_count, done_cnt, done_cyc, last_wr_cyc, timing_bad, hs_idx, first_addr;
  logic exp_we = 1'b0;

  task automatic clear_model();
    hs_idx = 0; wr_count = 0; done_cnt = 0; timing_bad = 0; exp_we = 1'b0;
    first_addr = -1; done_cyc = -1; last_wr_cyc = -100;
    for (int k = 0; k < WORDS; k++) mem_img[k] = '0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mem_we_o !== exp_we || mem_en_o !== mem_we_o) timing_bad++;
    if (mem_we_o === 1'b1) begin
      if (wr_count == 0) first_addr = int'(mem_addr_o);
      mem_img[mem_addr_o] = mem_wdata_o;
      if (mem_addr_o == (STAGES-1)'(WORDS-1)) last_wr_cyc = cyc;
      wr_count++;
    end
    if (done_o === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    exp_we = s_axis_tvalid && s_axis_tready && hs_idx[0];
    if (s_axis_tvalid && s_axis_tready) hs_idx++;
  end

  // Drives one frame; abort_at>=0 stops after that many accepted samples.
  task automatic run_frame(input int gap, input int bad_at, input int glitch_at,
                           input int idle_cyc, input int abort_at);
    int n, guard, lim;
    logic hs;
    n = 0; guard = 0;
    lim = (abort_at >= 0) ? abort_at : POINTS;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    if (idle_cyc > 0) begin
      s_axis_tvalid = 1'b0;
      repeat (idle_cyc) @(posedge clk);
      #1;
      check("stall_tready", s_axis_tready, 1);
      check("stall_busy", busy_o, 1);
      check("stall_no_write", wr_count, 0);
    end
    while (n < lim && guard < 20000) begin
      guard++;
      if (gap != 0 && $urandom_range(99) < 50) begin
        s_axis_tvalid = 1'b0;
      end else begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = samp(n);
        s_axis_tlast  = (n == POINTS - 1) || (n == bad_at);
      end
      start_i = (n == glitch_at);
      hs = s_axis_tvalid && s_axis_tready;
      if (hs && n == bad_at) check("err_before_bad_tlast", tlast_err_o, 0);
      @(posedge clk); #1;
      if (hs) begin
        if (n == bad_at) check("err_after_bad_tlast", tlast_err_o, 1);
        n++;
      end
    end
    start_i = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    if (guard >= 20000) check("frame_timeout", n, lim);
    if (abort_at < 0) begin
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  typedef struct { int addr; logic [31:0] word; } spot_t;
  spot_t spots[6];

  task automatic check_frame(input logic exp_err);
    int img_bad;
    img_bad = 0;
    for (int k = 0; k < WORDS; k++) if (mem_img[k] !== exp_word(k)) img_bad++;
    check("write_count", wr_count, WORDS);
    check("image_mismatches", img_bad, 0);
    for (int i = 0; i < 6; i++) check("spot_word", mem_img[spots[i].addr], spots[i].word);
    check("first_addr", first_addr, 0);
    check("done_pulses", done_cnt, 1);
    check("done_delay", done_cyc - last_wr_cyc, 1);
    check("write_timing_violations", timing_bad, 0);
    check("tlast_err", tlast_err_o, exp_err);
    check("busy_after", busy_o, 0);
  endtask

  typedef struct { int gap; int bad_at; int glitch_at; int idle; logic exp_err; } frame_t;
  frame_t frames[3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    spots[0] = '{0,   32'h00FF01FE};
    spots[1] = '{1,   32'h02FD03FC};
    spots[2] = '{127, 32'hFE01FF00};
    spots[3] = '{128, 32'h00FF01FE};
    spots[4] = '{200, 32'h906F916E};
    spots[5] = '{511, 32'hFE01FF00};
    frames[0] = '{0,  -1, 301, 0, 1'b0};  // steady stream, stray start in LOAD_ODD
    frames[1] = '{1,  -1,  -1, 0, 1'b0};  // 50% tvalid gaps
    frames[2] = '{0, 500,  -1, 0, 1'b1};  // early tlast

    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", s_axis_tready, 0);
    check("rst_mem_en", mem_en_o, 0);
    check("rst_mem_we", mem_we_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_wdata", mem_wdata_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", tlast_err_o, 0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    for (int f = 0; f < 3; f++) begin
      clear_model();
      run_frame(frames[f].gap, frames[f].bad_at, frames[f].glitch_at, frames[f].idle, -1);
      check_frame(frames[f].exp_err);
    end

    // Reset mid-frame after sample 301, with an early tlast at 10 to arm the error flag.
    clear_model();
    run_frame(0, 10, -1, 0, 302);
    check("err_before_abort", tlast_err_o, 1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    check("abort_tready", s_axis_tready, 0);
    check("abort_mem_en", mem_en_o, 0);
    check("abort_mem_we", mem_we_o, 0);
    check("abort_addr", mem_addr_o, 0);
    check("abort_wdata", mem_wdata_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_err", tlast_err_o, 0);
    check("abort_writes", wr_count, 151);
    check("abort_no_done", done_cnt, 0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Fresh frame after the abort, stalled for 20 cycles before data arrives.
    clear_model();
    run_frame(0, -1, -1, 20, -1);
    check_frame(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
